// File: rtl/sobel3x3_window.sv
// Sobel 3x3 gradient magnitude over three row-aligned pixel streams (y-1, y, y+1).
// Emits one AXI-Stream pixel per centre pixel, with zeroed borders and one synthetic end-of-line pixel.
module sobel3x3_window #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_HEIGHT = 1440
) (
    input  logic                  s_axis_aclk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_row0_tdata,
    input  logic [DATA_WIDTH-1:0] s_axis_row1_tdata,
    input  logic [DATA_WIDTH-1:0] s_axis_row2_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready
);
    localparam int GW = DATA_WIDTH + 3;
    localparam int RW = $clog2(IMG_HEIGHT) + 1;
    localparam int CW = 16;

    typedef enum logic {RUN, INSERT} state_t;
    state_t state, state_next;

    // Handshake: a transfer happens on any edge where valid & ready are both high; a valid
    // holder keeps its payload stable until that edge, and ready never depends on the same-side valid.
    logic en, accept, take, ins_fire, synced, ins_user;
    logic [CW-1:0] col, col_eff;
    logic [RW-1:0] row, row_eff;
    logic [DATA_WIDTH-1:0] win [3][3];
    logic [DATA_WIDTH-1:0] px_in [3];

    logic s1_valid, s1_border, s1_last, s1_user;
    logic s2_valid, s2_border, s2_last, s2_user;
    logic signed [GW-1:0] gx_c, gy_c, s2_gx, s2_gy;
    logic [GW-1:0] abs_x, abs_y, mag;
    logic [DATA_WIDTH-1:0] sat;

    function automatic logic signed [GW-1:0] ext(input logic [DATA_WIDTH-1:0] v);
        return $signed({3'b000, v});
    endfunction

    function automatic logic row_border(input logic [RW-1:0] r);
        return (r == '0) || (r == RW'(IMG_HEIGHT - 1));
    endfunction

    assign en            = m_axis_tready | ~m_axis_tvalid;
    assign s_axis_tready = en & (state == RUN) & ~reset;
    assign accept        = s_axis_tvalid & s_axis_tready;
    // Beats arriving before the first tuser after reset are swallowed without effect.
    assign take          = accept & (synced | s_axis_tuser);
    assign ins_fire      = en & (state == INSERT);
    assign col_eff       = s_axis_tuser ? '0 : col;
    assign row_eff       = s_axis_tuser ? '0 : row;

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (take && s_axis_tlast) state_next = INSERT;
            INSERT:  if (en) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        px_in[0] = take ? s_axis_row0_tdata : '0;
        px_in[1] = take ? s_axis_row1_tdata : '0;
        px_in[2] = take ? s_axis_row2_tdata : '0;
    end

    assign gx_c = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
                - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
    assign gy_c = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
                - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));

    assign abs_x = s2_gx[GW-1] ? -s2_gx : s2_gx;
    assign abs_y = s2_gy[GW-1] ? -s2_gy : s2_gy;
    assign mag   = abs_x + abs_y;
    assign sat   = (|mag[GW-1:DATA_WIDTH]) ? '1 : mag[DATA_WIDTH-1:0];

    always_ff @(posedge s_axis_aclk) begin
        if (reset) begin
            state    <= RUN;
            synced   <= 1'b0;
            col      <= '0;
            row      <= '0;
            ins_user <= 1'b0;
        end else begin
            state <= state_next;
            if (accept && s_axis_tuser) synced <= 1'b1;
            if (take) begin
                row <= s_axis_tlast ? row_eff + 1'b1 : row_eff;
                col <= s_axis_tlast ? '0 : ((col_eff == '1) ? col_eff : col_eff + 1'b1);
                // The inserted pixel sits at column W-1, the column of this tlast beat.
                if (s_axis_tlast) ins_user <= (row_eff == '0) && (col_eff == '0);
            end
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (reset) begin
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    win[r][k] <= '0;
            s1_valid      <= 1'b0;
            s1_border     <= 1'b0;
            s1_last       <= 1'b0;
            s1_user       <= 1'b0;
            s2_valid      <= 1'b0;
            s2_border     <= 1'b0;
            s2_last       <= 1'b0;
            s2_user       <= 1'b0;
            s2_gx         <= '0;
            s2_gy         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (en) begin
            if (take || ins_fire) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                    win[r][2] <= px_in[r];
                end
            end
            // A beat at column c completes the window centred on column c-1.
            s1_valid  <= (take && (col_eff != '0)) || ins_fire;
            s1_border <= ins_fire || (col_eff == CW'(1)) || row_border(row_eff);
            s1_last   <= ins_fire;
            s1_user   <= ins_fire ? ins_user : ((row_eff == '0) && (col_eff == CW'(1)));

            s2_valid  <= s1_valid;
            s2_border <= s1_border;
            s2_last   <= s1_last;
            s2_user   <= s1_user;
            s2_gx     <= gx_c;
            s2_gy     <= gy_c;

            m_axis_tvalid <= s2_valid;
            m_axis_tdata  <= (s2_valid && !s2_border) ? sat : '0;
            m_axis_tlast  <= s2_valid & s2_last;
            m_axis_tuser  <= s2_valid & s2_user;
        end
    end
endmodule

// File: tb/tb_sobel3x3_window.sv
// Randomized scoreboard bench for sobel3x3_window on a 6x4 image.
// Expected pixels come from a direct Sobel computation on the stored image.
module tb_sobel3x3_window;
    localparam int DW = 8;
    localparam int H  = 4;
    localparam int W  = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] s_axis_row0_tdata = '0;
    logic [DW-1:0] s_axis_row1_tdata = '0;
    logic [DW-1:0] s_axis_row2_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          m_axis_tready = 1'b1;

    sobel3x3_window #(.DATA_WIDTH(DW), .IMG_HEIGHT(H)) dut (
        .s_axis_aclk       (clk),
        .reset             (reset),
        .s_axis_row0_tdata (s_axis_row0_tdata),
        .s_axis_row1_tdata (s_axis_row1_tdata),
        .s_axis_row2_tdata (s_axis_row2_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tuser      (s_axis_tuser),
        .s_axis_tready     (s_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tuser      (m_axis_tuser),
        .m_axis_tready     (m_axis_tready)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    int img [H][W];
    logic [DW+1:0] exp_q [$];
    logic          bp_on = 1'b0;
    logic [3:0]    bp_pat = 4'b1001;
    int            bp_ph = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model
    function automatic int pix(int y, int x);
        if (y < 0 || y >= H || x < 0 || x >= W) return 0;
        return img[y][x];
    endfunction

    function automatic int model(int y, int x);
        int gx, gy, mag;
        if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
        gx = (pix(y-1, x+1) + 2 * pix(y, x+1) + pix(y+1, x+1))
           - (pix(y-1, x-1) + 2 * pix(y, x-1) + pix(y+1, x-1));
        gy = (pix(y+1, x-1) + 2 * pix(y+1, x) + pix(y+1, x+1))
           - (pix(y-1, x-1) + 2 * pix(y-1, x) + pix(y-1, x+1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag > (1 << DW) - 1) ? (1 << DW) - 1 : mag;
    endfunction

    task automatic push_exp(int y, int x);
        logic [DW+1:0] e;
        e = {(y == 0 && x == 0), (x == W - 1), DW'(model(y, x))};
        exp_q.push_back(e);
    endtask

    task automatic fill_img(int kind);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (kind)
                    0:       img[y][x] = 100;
                    1:       img[y][x] = (x < 3) ? 0 : 10;
                    2:       img[y][x] = (x >= y + 2) ? 255 : 0;
                    default: img[y][x] = int'($urandom_range(0, 255));
                endcase
    endtask

    // Driver tasks: every entry and exit sits at posedge+1
    task automatic drive_beat(input logic [DW-1:0] p0, p1, p2, input logic last, input logic user);
        int t = 0;
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        s_axis_row0_tdata = p0;
        s_axis_row1_tdata = p1;
        s_axis_row2_tdata = p2;
        s_axis_tlast      = last;
        s_axis_tuser      = user;
        s_axis_tvalid     = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!s_axis_tready && t < 200);
        if (!s_axis_tready) begin
            check("accept_timeout", s_axis_tready, 1);
            s_axis_tvalid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic drive_line(int y);
        for (int x = 0; x < W; x++) begin
            if (x >= 1) push_exp(y, x - 1);
            if (x == W - 1) push_exp(y, W - 1);
            drive_beat(DW'(pix(y-1, x)), DW'(pix(y, x)), DW'(pix(y+1, x)), x == W - 1, y == 0 && x == 0);
        end
        @(negedge clk);
        check("ready_low_after_last", s_axis_tready, 0);
        @(posedge clk); #1;
    endtask

    task automatic drive_frame();
        for (int y = 0; y < H; y++) drive_line(y);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_on) begin
                m_axis_tready = bp_pat[bp_ph];
                bp_ph = (bp_ph + 1) % 4;
            end else begin
                m_axis_tready = 1'b1;
            end
        end
    end

    // Scoreboard monitor
    logic          stalled = 1'b0;
    logic [DW+2:0] held = '0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled)
                check("stall_hold", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, held);
            if (m_axis_tvalid && !m_axis_tready)
                check("stall_no_input", s_axis_tready, 0);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", exp_q.size(), 1);
                end else begin
                    check($sformatf("out_pixel[%0d]", n_out),
                          {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
                end
                n_out++;
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held    = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_tdata"},  m_axis_tdata, 0);
        check({tag, "_tlast"},  m_axis_tlast, 0);
        check({tag, "_tuser"},  m_axis_tuser, 0);
        check({tag, "_s_tready"}, s_axis_tready, 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", s_axis_tready, 1);
        @(posedge clk); #1;

        fill_img(0); drive_frame(); drain();
        fill_img(1); drive_frame(); drain();
        fill_img(2); drive_frame(); drain();
        repeat (2) begin fill_img(3); drive_frame(); drain(); end

        bp_on = 1'b1;
        fill_img(1); drive_frame(); drain();
        fill_img(3); drive_frame(); drain();
        bp_on = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of row 2, column 3
        fill_img(0);
        drive_line(0);
        drive_line(1);
        for (int x = 0; x < 3; x++) begin
            if (x >= 1) push_exp(2, x - 1);
            drive_beat(DW'(pix(1, x)), DW'(pix(2, x)), DW'(pix(3, x)), 1'b0, 1'b0);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        drive_beat(8'd7, 8'd200, 8'd33, 1'b0, 1'b0);
        drive_beat(8'd90, 8'd1, 8'd250, 1'b0, 1'b0);
        drive_frame(); drain();

        // Early tuser at the start of row 2
        fill_img(1);
        drive_line(0);
        drive_line(1);
        fill_img(3);
        drive_frame(); drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
